// File: rtl/chirp_adc_sampler.sv
// chirp_adc_sampler
// Paces an IF ADC during FMCW chirps and streams the kept samples out through a
// first-word-fall-through buffer.
//   clk, rst            : single clock, synchronous active-high reset
//   enable_i            : low forces IDLE and restarts the chirp count
//   chirp_start_i/done_i: ramp start / ramp end pulses from the VCO stage
//   chirp_num_i, sample_psc_i, settle_num_i, sample_num_i : per-chirp config,
//                         latched when a chirp starts
//   adc_data_i, adc_clk_o : ADC parallel data in, ADC sample clock out
//   m_*                 : valid/ready sample stream with chirp index and
//                         last / frame_last sidebands
//   clr_err_i, overflow_o, truncated_o : sticky error flags and their clear
//   busy_o              : FSM not IDLE
module chirp_adc_sampler #(
  parameter int SYS_CLK_FREQ_MHZ = 50,
  parameter int ADC_WIDTH        = 12,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 chirp_start_i,
  input  logic                 chirp_done_i,
  input  logic [4:0]           chirp_num_i,
  input  logic [15:0]          sample_psc_i,
  input  logic [7:0]           settle_num_i,
  input  logic [9:0]           sample_num_i,
  input  logic [ADC_WIDTH-1:0] adc_data_i,
  output logic                 adc_clk_o,
  output logic [ADC_WIDTH-1:0] m_data_o,
  output logic [4:0]           m_chirp_idx_o,
  output logic                 m_last_o,
  output logic                 m_frame_last_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  input  logic                 clr_err_i,
  output logic                 overflow_o,
  output logic                 truncated_o,
  output logic                 busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, WAIT_END} state_t;

  typedef struct packed {
    logic [ADC_WIDTH-1:0] data;
    logic [4:0]           idx;
    logic                 last;
    logic                 frame_last;
  } smp_t;

  // The clock frequency only matters to whoever picks sample_psc_i.
  logic unused_freq;
  assign unused_freq = (SYS_CLK_FREQ_MHZ > 0);

  state_t        state_q, state_d;
  logic [15:0]   psc_q, psc_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d;
  logic [15:0]   psc_cfg_q, psc_cfg_d;
  logic [7:0]    settle_cfg_q, settle_cfg_d;
  logic [9:0]    samp_cfg_q, samp_cfg_d;
  logic [4:0]    chirp_cfg_q, chirp_cfg_d;
  logic          adc_clk_q, adc_clk_d;
  logic          ovf_q, ovf_d;
  logic          trunc_q, trunc_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  smp_t          mem_q [FIFO_DEPTH];
  smp_t          mem_d [FIFO_DEPTH];

  logic          strobe;
  logic          push, pop, wr_en, full, empty;
  logic          trunc_set, ovf_set, is_last;
  logic [4:0]    idx_next;
  smp_t          push_data;
  smp_t          head;

  assign strobe   = (state_q != IDLE) && (psc_q == psc_cfg_q - 16'd1);
  // Compare with >= so a stale index can never run past the wrap point.
  assign idx_next = (idx_q >= chirp_cfg_q - 5'd1) ? 5'd0 : idx_q + 5'd1;

  // ---------------- sequencing FSM ----------------
  always_comb begin
    state_d      = state_q;
    psc_d        = strobe ? 16'd0 : psc_q + 16'd1;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    psc_cfg_d    = psc_cfg_q;
    settle_cfg_d = settle_cfg_q;
    samp_cfg_d   = samp_cfg_q;
    chirp_cfg_d  = chirp_cfg_q;
    push         = 1'b0;
    push_data    = '0;
    trunc_set    = 1'b0;
    is_last      = 1'b0;

    case (state_q)
      IDLE: begin
        if (chirp_start_i && enable_i) begin
          psc_cfg_d    = (sample_psc_i < 16'd2) ? 16'd2 : sample_psc_i;
          settle_cfg_d = settle_num_i;
          samp_cfg_d   = (sample_num_i == 10'd0) ? 10'd1 : sample_num_i;
          chirp_cfg_d  = (chirp_num_i == 5'd0) ? 5'd1 : chirp_num_i;
          cnt_d        = '0;
          state_d      = (settle_num_i == 8'd0) ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (chirp_done_i) begin
          trunc_set = 1'b1;
          idx_d     = idx_next;
          state_d   = IDLE;
        end else if (strobe) begin
          if (cnt_q == {2'b00, settle_cfg_q} - 10'd1) begin
            cnt_d   = '0;
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      SAMPLE: begin
        // A ramp end that lands on a strobe still truncates: the chirp never
        // produces its last sample.
        if (chirp_done_i) begin
          trunc_set = 1'b1;
          idx_d     = idx_next;
          state_d   = IDLE;
        end else if (strobe) begin
          is_last              = (cnt_q == samp_cfg_q - 10'd1);
          push                 = 1'b1;
          push_data.data       = adc_data_i;
          push_data.idx        = idx_q;
          push_data.last       = is_last;
          push_data.frame_last = is_last && (idx_q == chirp_cfg_q - 5'd1);
          if (is_last) state_d = WAIT_END;
          else         cnt_d   = cnt_q + 10'd1;
        end
      end
      WAIT_END: begin
        if (chirp_done_i) begin
          idx_d   = idx_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable_i) begin
      state_d   = IDLE;
      idx_d     = '0;
      push      = 1'b0;
      trunc_set = 1'b0;
    end

    // Prescaler only runs outside IDLE and restarts at 0 when leaving it.
    if (state_d == IDLE || state_q == IDLE) psc_d = '0;
    // Computed from next-state values so adc_clk_o lines up with psc_q.
    adc_clk_d = (state_d != IDLE) && (psc_d >= (psc_cfg_d >> 1));
  end

  // ---------------- output FIFO (first-word-fall-through) ----------------
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && m_ready_i;
  // A pop in the same cycle frees the slot, so a push into a full buffer
  // is only lost when nothing drains.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q[AW-1:0]] = push_data;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    // A new error in the clearing cycle keeps the flag set.
    ovf_d    = (ovf_q   && !clr_err_i) || ovf_set;
    trunc_d  = (trunc_q && !clr_err_i) || trunc_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      psc_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      psc_cfg_q    <= 16'd2;
      settle_cfg_q <= '0;
      samp_cfg_q   <= 10'd1;
      chirp_cfg_q  <= 5'd1;
      adc_clk_q    <= 1'b0;
      ovf_q        <= 1'b0;
      trunc_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      psc_q        <= psc_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      psc_cfg_q    <= psc_cfg_d;
      settle_cfg_q <= settle_cfg_d;
      samp_cfg_q   <= samp_cfg_d;
      chirp_cfg_q  <= chirp_cfg_d;
      adc_clk_q    <= adc_clk_d;
      ovf_q        <= ovf_d;
      trunc_q      <= trunc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
    end
  end

  assign head           = mem_q[rd_ptr_q[AW-1:0]];
  assign m_data_o       = head.data;
  assign m_chirp_idx_o  = head.idx;
  assign m_last_o       = head.last;
  assign m_frame_last_o = head.frame_last;
  assign m_valid_o      = !empty;
  assign adc_clk_o      = adc_clk_q;
  assign overflow_o     = ovf_q;
  assign truncated_o    = trunc_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_chirp_adc_sampler.sv
// Self-checking bench for chirp_adc_sampler. adc_data_i carries the cycle
// number, so every kept sample's value follows from when it was captured.
module tb_chirp_adc_sampler;
  localparam int AWD   = 12;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable_i = 1'b0, chirp_start_i = 1'b0, chirp_done_i = 1'b0;
  logic [4:0]     chirp_num_i = '0;
  logic [15:0]    sample_psc_i = '0;
  logic [7:0]     settle_num_i = '0;
  logic [9:0]     sample_num_i = '0;
  logic [AWD-1:0] adc_data_i;
  logic           adc_clk_o;
  logic [AWD-1:0] m_data_o;
  logic [4:0]     m_chirp_idx_o;
  logic           m_last_o, m_frame_last_o, m_valid_o;
  logic           m_ready_i = 1'b0;
  logic           clr_err_i = 1'b0;
  logic           overflow_o, truncated_o, busy_o;

  chirp_adc_sampler #(.SYS_CLK_FREQ_MHZ(50), .ADC_WIDTH(AWD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .chirp_start_i(chirp_start_i),
    .chirp_done_i(chirp_done_i), .chirp_num_i(chirp_num_i), .sample_psc_i(sample_psc_i),
    .settle_num_i(settle_num_i), .sample_num_i(sample_num_i), .adc_data_i(adc_data_i),
    .adc_clk_o(adc_clk_o), .m_data_o(m_data_o), .m_chirp_idx_o(m_chirp_idx_o),
    .m_last_o(m_last_o), .m_frame_last_o(m_frame_last_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .clr_err_i(clr_err_i), .overflow_o(overflow_o),
    .truncated_o(truncated_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign adc_data_i = cyc[AWD-1:0];

  typedef struct packed {
    logic [AWD-1:0] data;
    logic [4:0]     idx;
    logic           last;
    logic           fl;
  } exp_t;

  typedef struct {
    int p, s, n, c, runs, exp_out, exp_last, exp_fl;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0;
  int   mon_cnt = 0, mon_last = 0, mon_fl = 0;
  int   exp_idx = 0;
  bit   stall_prev = 0;
  bit   rand_ready = 0;
  logic ready_lvl = 1'b1;
  exp_t prev_out, cur_out, mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Ready changes just after the rising edge so the negedge monitor and the
  // DUT see the same value.
  initial forever begin
    @(posedge clk);
    #1;
    m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
  end

  // Scoreboard monitor: compare each handshake against the queue head and
  // require the head to hold while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      cur_out = {m_data_o, m_chirp_idx_o, m_last_o, m_frame_last_o};
      if (stall_prev) chk("hold_stalled", {m_valid_o, cur_out}, {1'b1, prev_out});
      if (m_valid_o && m_ready_i) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_output actual=%0h expected=none", cur_out);
        end else begin
          mon_e = sbq.pop_front();
          chk("sample_out", cur_out, mon_e);
          mon_cnt++;
          if (m_last_o) mon_last++;
          if (m_frame_last_o) mon_fl++;
        end
      end
      stall_prev = m_valid_o && !m_ready_i;
      prev_out   = cur_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input logic [31:0] target);
    int g = 0;
    while (cyc < target && g < 5000) begin @(negedge clk); g++; end
    if (g >= 5000) begin
      checks++; errors++;
      $display("FAIL wait_timeout actual=%0d expected=%0d", cyc, target);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sbq.size() != 0 || m_valid_o) && g < 3000) begin @(negedge clk); g++; end
    chk("drain_left", sbq.size(), 0);
    tick(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    tick(2);
    rst = 1'b0;
    exp_idx = 0;
    mon_cnt = 0; mon_last = 0; mon_fl = 0;
  endtask

  // One chirp. trunc>=0 ends the ramp after that many kept samples; kill>=0
  // drops enable_i after that many.
  task automatic run_chirp(input int p, input int s, input int n, input int c,
                           input int trunc, input int kill);
    int pe, ne, ce, nk;
    logic [31:0] t0;
    exp_t e;
    pe = (p < 2) ? 2 : p;
    ne = (n == 0) ? 1 : n;
    ce = (c == 0) ? 1 : c;
    nk = (trunc >= 0) ? trunc : ((kill >= 0) ? kill : ne);
    @(negedge clk);
    sample_psc_i = 16'(p); settle_num_i = 8'(s); sample_num_i = 10'(n);
    chirp_num_i = 5'(c); chirp_start_i = 1'b1;
    t0 = cyc;
    for (int k = 0; k < nk; k++) begin
      e.data = AWD'(t0 + 32'((s + k + 1) * pe));
      e.idx  = 5'(exp_idx);
      e.last = (trunc < 0 && kill < 0 && k == ne - 1);
      e.fl   = e.last && (exp_idx == ce - 1);
      sbq.push_back(e);
    end
    @(negedge clk);
    chirp_start_i = 1'b0;
    // Junk on the config inputs must not disturb the running chirp.
    sample_psc_i = 16'd7; settle_num_i = 8'd9; sample_num_i = 10'd3; chirp_num_i = 5'd1;
    chk("busy_run", busy_o, 1);
    for (int i = 1; i <= 2 * pe; i++) begin
      wait_cyc(t0 + 32'(i));
      chk("adc_clk_phase", adc_clk_o, 32'(((i - 1) % pe) >= pe / 2));
    end
    if (s >= 2 && !rand_ready && ready_lvl && sbq.size() == nk) begin
      wait_cyc(t0 + 32'((s + 1) * pe));
      chk("first_lat_before", m_valid_o, 0);
      wait_cyc(t0 + 32'((s + 1) * pe + 1));
      chk("first_lat_at", m_valid_o, 1);
    end
    if (trunc >= 0) begin
      wait_cyc(t0 + 32'((s + trunc) * pe + 1));
      chirp_done_i = 1'b1; tick(1); chirp_done_i = 1'b0;
      chk("trunc_flag", truncated_o, 1);
      chk("trunc_idle", busy_o, 0);
      exp_idx = (exp_idx + 1) % ce;
    end else if (kill >= 0) begin
      wait_cyc(t0 + 32'((s + kill) * pe + 1));
      enable_i = 1'b0; tick(1); enable_i = 1'b1;
      chk("disable_idle", busy_o, 0);
      exp_idx = 0;
    end else begin
      wait_cyc(t0 + 32'((s + ne) * pe + 1));
      chk("wait_end_busy", busy_o, 1);
      chirp_done_i = 1'b1; tick(1); chirp_done_i = 1'b0;
      chk("done_idle", busy_o, 0);
      chk("adc_clk_idle", adc_clk_o, 0);
      exp_idx = (exp_idx + 1) % ce;
    end
  endtask

  vec_t tbl[4];

  initial begin
    //          p  s  n  c runs out last fl
    tbl[0] = '{4, 2, 8, 2, 2, 16, 2, 1};
    tbl[1] = '{1, 0, 3, 1, 2,  6, 2, 2};
    tbl[2] = '{3, 1, 0, 0, 3,  3, 3, 3};
    tbl[3] = '{5, 3, 4, 3, 3, 12, 3, 1};

    // Reset state
    tick(3);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_adc_clk", adc_clk_o, 0);
    chk("rst_flags", {overflow_o, truncated_o}, 0);
    chk("rst_out", {m_data_o, m_chirp_idx_o, m_last_o, m_frame_last_o}, 0);
    rst = 1'b0;

    // Start while disabled is ignored
    @(negedge clk); chirp_start_i = 1'b1; tick(1); chirp_start_i = 1'b0;
    chk("start_disabled", busy_o, 0);
    enable_i = 1'b1;

    // Table-driven scenarios, ready held high
    for (int v = 0; v < 4; v++) begin
      do_reset();
      ready_lvl = 1'b1;
      for (int r = 0; r < tbl[v].runs; r++) begin
        run_chirp(tbl[v].p, tbl[v].s, tbl[v].n, tbl[v].c, -1, -1);
        tick(2);
      end
      wait_drain();
      chk("tbl_out_cnt", mon_cnt, tbl[v].exp_out);
      chk("tbl_last_cnt", mon_last, tbl[v].exp_last);
      chk("tbl_fl_cnt", mon_fl, tbl[v].exp_fl);
      chk("tbl_flags", {overflow_o, truncated_o}, 0);
    end

    // Overflow: 20 samples into a 16-deep buffer with no drain
    ready_lvl = 1'b0;
    do_reset();
    run_chirp(2, 0, 20, 1, -1, -1);
    while (sbq.size() > DEPTH) void'(sbq.pop_back());
    chk("ovf_set", overflow_o, 1);
    chk("ovf_trunc_clear", truncated_o, 0);
    chk("ovf_valid", m_valid_o, 1);
    clr_err_i = 1'b1; tick(1); clr_err_i = 1'b0;
    chk("ovf_clr", overflow_o, 0);
    ready_lvl = 1'b1;
    wait_drain();
    chk("ovf_retained", mon_cnt, DEPTH);

    // Truncation after 3 of 8, then a full chirp with the next index
    do_reset();
    run_chirp(4, 1, 8, 4, 3, -1);
    wait_drain();
    chk("trunc_out_cnt", mon_cnt, 3);
    chk("trunc_no_last", mon_last, 0);
    run_chirp(4, 1, 8, 4, -1, -1);
    wait_drain();
    chk("trunc_next_last", mon_last, 1);
    clr_err_i = 1'b1; tick(1); clr_err_i = 1'b0;
    chk("trunc_clr", truncated_o, 0);

    // Enable drop mid-SAMPLE with samples still buffered
    do_reset();
    run_chirp(4, 1, 8, 4, -1, -1);
    wait_drain();
    ready_lvl = 1'b0;
    run_chirp(4, 1, 8, 4, -1, 2);
    tick(2);
    chk("dis_buffered", m_valid_o, 1);
    ready_lvl = 1'b1;
    wait_drain();
    run_chirp(4, 1, 8, 4, -1, -1);
    wait_drain();
    chk("dis_out_cnt", mon_cnt, 18);

    // Reset mid-chirp discards buffered samples
    ready_lvl = 1'b0;
    do_reset();
    @(negedge clk);
    sample_psc_i = 16'd2; settle_num_i = 8'd0; sample_num_i = 10'd10; chirp_num_i = 5'd1;
    chirp_start_i = 1'b1; tick(1); chirp_start_i = 1'b0;
    tick(8);
    chk("pre_rst_valid", m_valid_o, 1);
    rst = 1'b1; tick(1);
    chk("midrst_valid", m_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    rst = 1'b0;
    ready_lvl = 1'b1;

    // Random backpressure across 4 chirps
    do_reset();
    rand_ready = 1;
    for (int r = 0; r < 4; r++) begin
      run_chirp(3, 1, 6, 4, -1, -1);
      tick(2);
    end
    wait_drain();
    rand_ready = 0;
    chk("rnd_out_cnt", mon_cnt, 24);
    chk("rnd_fl_cnt", mon_fl, 1);
    chk("rnd_ovf", overflow_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d expected=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
